// File: rtl/prim_skid_buf.sv
// prim_skid_buf: two-entry skid buffer that registers both directions of a
// valid/ready handshake. ready_o, valid_o and data_o all come straight from
// flops. An optional stall counter is compiled in when the macro
// PRIM_SKID_BUF_STALL_CNT_EN is defined; otherwise stall_cnt_o is tied to 0.
module prim_skid_buf #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic [15:0]      stall_cnt_o,
    input  logic             stall_clr_i
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             in_xfer, out_xfer;

    // Handshakes use the registered outputs, so no input reaches an output
    // without passing through a flop.
    assign in_xfer  = valid_i & ready_q;
    assign out_xfer = valid_q & ready_i;

    // State register plus the registered handshake outputs and main entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    // Skid entry is only ever read in FULL, so it needs no reset.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_d;
    end

    // Next-state logic: occupancy moves by +1 on input-only, -1 on output-only.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (in_xfer) state_d = StBusy;
            StBusy: begin
                if (in_xfer && !out_xfer)      state_d = StFull;
                else if (!in_xfer && out_xfer) state_d = StEmpty;
            end
            StFull:  if (out_xfer) state_d = StBusy;
            default: state_d = StEmpty;
        endcase
    end

    // Payload steering: main always holds the oldest word, skid the younger.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        unique case (state_q)
            StEmpty: if (in_xfer) main_d = data_i;
            StBusy: begin
                if (in_xfer && out_xfer)  main_d = data_i;
                if (in_xfer && !out_xfer) skid_d = data_i;
            end
            StFull:  if (out_xfer) main_d = skid_q;
            default: ;
        endcase
    end

    // Output decode from the next state, so the flopped outputs match the state.
    always_comb begin
        ready_d = (state_d != StFull);
        valid_d = (state_d != StEmpty);
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = main_q;

`ifdef PRIM_SKID_BUF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: clear wins over increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr_i) begin
            stall_cnt_d = '0;
        end else if (valid_q && !ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr_i;
    assign stall_cnt_o      = '0;
`endif

endmodule
